// File: rtl/clk_edge_monitor_if.sv
// Signal bundle between a clock-edge monitor and whatever drives/observes it.
// master drives enable and the monitored clock; slave is the monitor itself.
interface clk_edge_monitor_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             mon_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic             len_valid;
    logic [CNT_W-1:0] cyc_cnt;
    logic             period_err;
    logic [CNT_W-1:0] err_count;
    logic             done;

    modport master (
        output en, mon_in,
        input  rise_pulse, fall_pulse, high_len, low_len, len_valid,
               cyc_cnt, period_err, err_count, done
    );

    modport slave (
        input  en, mon_in,
        output rise_pulse, fall_pulse, high_len, low_len, len_valid,
               cyc_cnt, period_err, err_count, done
    );
endinterface

// File: rtl/clk_edge_monitor.sv
// Samples a free-running clock, measures high/low phases in clk cycles and flags out-of-tolerance ones.
// Edge pulses register SYNC_STAGES clk edges after the first sampling edge; no backpressure, en=0 parks in IDLE.
module clk_edge_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EXP_HIGH    = 1,
    parameter int EXP_LOW     = 1,
    parameter int TOL         = 0,
    parameter int TARGET_CYC  = 10
) (
    input logic              clk,
    input logic              rst_n,
    clk_edge_monitor_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT      = 3'd1;
    localparam logic [2:0] S_MEAS_LOW  = 3'd2;
    localparam logic [2:0] S_MEAS_HIGH = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TGT     = CNT_W'(TARGET_CYC);
    localparam logic [31:0] LO_H = (EXP_HIGH > TOL) ? 32'(EXP_HIGH - TOL) : 32'd0;
    localparam logic [31:0] HI_H = 32'(EXP_HIGH + TOL);
    localparam logic [31:0] LO_L = (EXP_LOW > TOL) ? 32'(EXP_LOW - TOL) : 32'd0;
    localparam logic [31:0] HI_L = 32'(EXP_LOW + TOL);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_run_len;
    logic [2:0]             r_state;
    logic                   r_rise_pulse;
    logic                   r_fall_pulse;
    logic                   r_len_valid;
    logic [CNT_W-1:0]       r_high_len;
    logic [CNT_W-1:0]       r_low_len;
    logic [CNT_W-1:0]       r_cyc_cnt;
    logic                   r_period_err;
    logic [CNT_W-1:0]       r_err_count;
    logic                   r_done;

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic [31:0]      w_run32;
    logic             w_high_bad;
    logic             w_low_bad;
    logic [CNT_W-1:0] w_cyc_next;
    logic [CNT_W-1:0] w_err_next;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_s & ~r_prev;
    assign w_fall     = ~w_s & r_prev;
    assign w_run32    = 32'(r_run_len);
    assign w_high_bad = (w_run32 < LO_H) || (w_run32 > HI_H);
    assign w_low_bad  = (w_run32 < LO_L) || (w_run32 > HI_L);
    assign w_cyc_next = (r_cyc_cnt == CNT_MAX) ? r_cyc_cnt : r_cyc_cnt + 1'b1;
    assign w_err_next = (r_err_count == CNT_MAX) ? r_err_count : r_err_count + 1'b1;

    // Synchronizer and run-length tracker run regardless of en so that
    // re-enabling mid-phase never sees a stale level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_prev    <= 1'b0;
            r_run_len <= '0;
        end else begin
            r_sync[0] <= bus.mon_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= w_s;
            if (w_rise || w_fall) begin
                r_run_len <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (r_run_len != CNT_MAX) begin
                r_run_len <= r_run_len + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
            r_len_valid  <= 1'b0;
            r_high_len   <= '0;
            r_low_len    <= '0;
            r_cyc_cnt    <= '0;
            r_period_err <= 1'b0;
            r_err_count  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_rise_pulse <= w_rise & bus.en;
            r_fall_pulse <= w_fall & bus.en;
            r_len_valid  <= 1'b0;
            if (!bus.en) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cyc_cnt    <= '0;
                        r_err_count  <= '0;
                        r_period_err <= 1'b0;
                        r_done       <= 1'b0;
                        r_state      <= S_WAIT;
                    end
                    // The phase in progress at arm time is of unknown length.
                    S_WAIT: begin
                        if (w_fall) begin
                            r_state <= S_MEAS_LOW;
                        end
                    end
                    S_MEAS_LOW: begin
                        if (w_rise) begin
                            r_low_len <= r_run_len;
                            r_cyc_cnt <= w_cyc_next;
                            if (w_low_bad) begin
                                r_period_err <= 1'b1;
                                r_err_count  <= w_err_next;
                            end
                            if ((TARGET_CYC != 0) && (w_cyc_next == TGT)) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_MEAS_HIGH;
                            end
                        end
                    end
                    S_MEAS_HIGH: begin
                        if (w_fall) begin
                            r_high_len  <= r_run_len;
                            r_len_valid <= 1'b1;
                            if (w_high_bad) begin
                                r_period_err <= 1'b1;
                                r_err_count  <= w_err_next;
                            end
                            r_state <= S_MEAS_LOW;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rise_pulse = r_rise_pulse;
    assign bus.fall_pulse = r_fall_pulse;
    assign bus.len_valid  = r_len_valid;
    assign bus.high_len   = r_high_len;
    assign bus.low_len    = r_low_len;
    assign bus.cyc_cnt    = r_cyc_cnt;
    assign bus.period_err = r_period_err;
    assign bus.err_count  = r_err_count;
    assign bus.done       = r_done;
endmodule
